// File: rtl/redun_carry_resolve_if.sv
// rtl/redun_carry_resolve_if.sv - handshake bundle for the redundant carry resolver
//
// Purpose: carries the redundant operand in, the canonical result out, and
// the valid/ready pairs of both directions.
// Ports (signals):
//   i_dat  NUM_WRDS*(WRD_BITS+1)  redundant operand, word k at k*(WRD_BITS+1)
//   i_val  1                      operand valid
//   o_rdy  1                      resolver accepts an operand
//   o_dat  NUM_WRDS*WRD_BITS      canonical result, sum mod 2^DAT_BITS
//   o_ovf  1                      final carry was nonzero
//   o_val  1                      o_dat/o_ovf valid
//   i_rdy  1                      downstream accepts the result
// Modports: master = operand source / result sink, slave = resolver.
interface redun_carry_resolve_if #(
  parameter int WRD_BITS = 16,
  parameter int NUM_WRDS = 65
);
  logic [NUM_WRDS*(WRD_BITS+1)-1:0] i_dat;
  logic                             i_val;
  logic                             o_rdy;
  logic [NUM_WRDS*WRD_BITS-1:0]     o_dat;
  logic                             o_ovf;
  logic                             o_val;
  logic                             i_rdy;

  modport master (
    output i_dat, i_val, i_rdy,
    input  o_rdy, o_dat, o_ovf, o_val
  );

  modport slave (
    input  i_dat, i_val, i_rdy,
    output o_rdy, o_dat, o_ovf, o_val
  );
endinterface

// File: rtl/redun_carry_resolve.sv
// rtl/redun_carry_resolve.sv - resolves a redundant (WRD_BITS+1)-bit-per-word operand into binary
//
// Purpose: converts NUM_WRDS redundant words (each WRD_BITS+1 bits, weight
// 2^(k*WRD_BITS)) into the canonical DAT_BITS-bit sum, WRDS_PER_CYC words per
// cycle, carrying a 2-bit inter-word carry.
// Ports:
//   i_clk  1      rising-edge clock
//   i_rst  1      asynchronous active-high reset
//   bus    slave  operand in (i_dat/i_val/o_rdy), result out (o_dat/o_ovf/o_val/i_rdy)
module redun_carry_resolve #(
  parameter int WRD_BITS     = 16,
  parameter int NUM_WRDS     = 65,
  parameter int WRDS_PER_CYC = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  redun_carry_resolve_if.slave  bus
);

  localparam int RW        = WRD_BITS + 1;
  localparam int DAT_BITS  = NUM_WRDS * WRD_BITS;
  localparam int IN_BITS   = NUM_WRDS * RW;
  localparam int NCHUNK    = NUM_WRDS / WRDS_PER_CYC;
  localparam int CHUNK_IN  = WRDS_PER_CYC * RW;
  localparam int CHUNK_OUT = WRDS_PER_CYC * WRD_BITS;
  localparam int CNT_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   rdy_q, rdy_d;
  logic                   accept;
  logic [IN_BITS-1:0]     wrd_q;
  logic [DAT_BITS-1:0]    dat_q;
  logic                   ovf_q;
  logic                   val_q;
  logic [1:0]             carry_q, carry_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CHUNK_OUT-1:0]   chunk_res;
  logic [RW:0]            sum;
  logic [1:0]             rip;

  // The lowest chunk of wrd_q is always the one being resolved: the word
  // register shifts down by one chunk per RUN cycle, so no indexed select
  // by the counter is needed.
  always_comb begin
    chunk_res = '0;
    sum       = '0;
    rip       = carry_q;
    for (int j = 0; j < WRDS_PER_CYC; j++) begin
      sum = {1'b0, wrd_q[j*RW +: RW]} + {{(RW-1){1'b0}}, rip};
      chunk_res[j*WRD_BITS +: WRD_BITS] = sum[WRD_BITS-1:0];
      // A 17-bit word plus a carry of at most 2 never carries out more than 2.
      rip = sum[WRD_BITS+1:WRD_BITS];
    end
    carry_d = rip;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_val && rdy_q) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CHUNK) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready only rises after a full cycle in IDLE, so the release edge of
    // DONE never doubles as an accept edge.
    rdy_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      wrd_q   <= '0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
      val_q   <= 1'b0;
      carry_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            wrd_q   <= bus.i_dat;
            carry_q <= 2'd0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          wrd_q   <= wrd_q >> CHUNK_IN;
          // Results enter at the top and walk down, so after the last chunk
          // chunk 0 sits at the bottom of dat_q.
          dat_q   <= {chunk_res, dat_q[DAT_BITS-1:CHUNK_OUT]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CHUNK) begin
            val_q <= 1'b1;
            ovf_q <= (carry_d != 2'd0);
          end
        end
        DONE: begin
          if (bus.i_rdy) begin
            val_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_rdy = rdy_q;
  assign bus.o_dat = dat_q;
  assign bus.o_ovf = ovf_q;
  assign bus.o_val = val_q;

endmodule
